// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative RV32M multiply/divide unit.
//   op_t    : M-extension funct3 encodings
//   state_t : controller states
//   is_div / is_rem / is_signed_a / is_signed_b : per-op decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic is_div(input op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // MUL is treated as unsigned: its low half is identical for any signedness.
    function automatic logic is_signed_a(input op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle between the core and muldiv_unit.
//   in_valid/in_ready/op/a/b : request channel
//   kill                     : abort of the in-flight op
//   out_valid/out_ready/result : response channel
//   busy                     : unit not idle
//   master = core side, slave = unit side
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate.
//   neg  : negate when 1, pass through when 0
//   din  : W-bit input
//   dout : W-bit output
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    assign dout = neg ? (~din + W'(1)) : din;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (all eight M-extension ops).
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : muldiv_if.slave (request, response, kill, busy)
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// (XLEN+1)x(XLEN+1) signed product in FIX and skip CALC; divide unchanged.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a request, in_ready=1
//   CALC   | XLEN shift-add (mul) or restoring-subtract (div) iterations
//   FIX    | sign correction and result half / quotient / remainder select
//   DONE   | out_valid=1, result held until out_ready
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;

    state_t              state;
    op_t                 op_q;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc;      // mul: {hi, lo/multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     mb;       // multiplicand / divisor magnitude
    logic                neg_q;    // product or quotient sign
    logic                neg_r;    // remainder sign
    logic [XLEN-1:0]     result_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    op_t                 op_in;
    logic                neg_a_in;
    logic                neg_b_in;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                div0;
    logic                ovf;
    logic [XLEN-1:0]     special_res;

    assign op_in    = op_t'(bus.op);
    assign neg_a_in = is_signed_a(op_in) & bus.a[XLEN-1];
    assign neg_b_in = is_signed_b(op_in) & bus.b[XLEN-1];
    assign div0     = is_div(op_in) && (bus.b == '0);
    assign ovf      = (op_in == OP_DIV || op_in == OP_REM)
                      && (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.b == '1);

    muldiv_sign_fix #(.W(XLEN)) u_fix_a (.neg(neg_a_in), .din(bus.a), .dout(mag_a));
    muldiv_sign_fix #(.W(XLEN)) u_fix_b (.neg(neg_b_in), .din(bus.b), .dout(mag_b));

    always_comb begin
        special_res = '0;
        if (div0)
            special_res = is_rem(op_in) ? bus.a : '1;
        else
            special_res = is_rem(op_in) ? '0 : bus.a;
    end

    // One iteration of each algorithm.
    logic [XLEN-1:0]   mul_add;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_add  = acc[0] ? mb : '0;
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_add};
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // Shifted partial remainder needs XLEN+1 bits when the divisor's MSB is set.
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        div_sub  = rem_sh[XLEN-1:0] - mb;
        if (rem_sh >= {1'b0, mb})
            div_next = {div_sub, acc[XLEN-2:0], 1'b1};
        else
            div_next = {acc[2*XLEN-2:0], 1'b0};
    end

    // Negating the whole {rem, quo} pair gives -quo in the low half, so one
    // wide instance serves both the product and the quotient.
    logic [2*XLEN-1:0] wide_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_wide (.neg(neg_q), .din(acc), .dout(wide_fix));
    muldiv_sign_fix #(.W(XLEN))   u_fix_rem  (.neg(neg_r), .din(acc[2*XLEN-1:XLEN]), .dout(rem_fix));

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN:0]     fa;
    logic [XLEN:0]     fb;
    logic [2*XLEN-1:0] fprod;
    always_comb begin
        fa    = {is_signed_a(op_q) & acc[XLEN-1], acc[XLEN-1:0]};
        fb    = {is_signed_b(op_q) & mb[XLEN-1], mb};
        fprod = {{(XLEN-1){fa[XLEN]}}, fa} * {{(XLEN-1){fb[XLEN]}}, fb};
    end
`endif

    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL, OP_DIV, OP_DIVU:     fix_res = wide_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = wide_fix[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:             fix_res = rem_fix;
            default:                     fix_res = '0;
        endcase
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div(op_q))
            fix_res = (op_q == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            op_q        <= OP_MUL;
            cnt         <= '0;
            acc         <= '0;
            mb          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.kill && state != S_IDLE) begin
            state       <= S_IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && !bus.kill) begin
                        op_q       <= op_in;
                        neg_q      <= neg_a_in ^ neg_b_in;
                        neg_r      <= neg_a_in;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (div0 || ovf) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, mag_a};
                            mb    <= mag_b;
                            state <= S_CALC;
`ifdef MULDIV_FAST_MUL_EN
                            if (!is_div(op_in)) begin
                                acc   <= {{XLEN{1'b0}}, bus.a};
                                mb    <= bus.b;
                                state <= S_FIX;
                            end
`endif
                        end
                    end
                end
                S_CALC: begin
                    acc <= is_div(op_q) ? div_next : mul_next;
                    if (cnt == CW'(XLEN - 1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int DIV_LAT = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with it idle again.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat);
        int   n;
        logic rdy_seen;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.op        = o;
        bus.a         = x;
        bus.b         = y;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n        = 0;
        rdy_seen = 1'b0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_ready_low"}, 32'(rdy_seen), 32'd0);
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       stable;
        logic       seen;
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.a         = '0;
        bus.b         = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    bus.result,         32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op("mul_7x6",    3'b000, 32'd7,        32'd6,        32'd42,       MUL_LAT);
        do_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        do_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        do_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
        do_op("mul_m1x3",   3'b000, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, MUL_LAT);
        do_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
        do_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
        do_op("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
        do_op("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
        do_op("div_7_m2",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
        do_op("rem_7_m2",   3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT);
        do_op("divu_big",   3'b101, 32'hFFFFFFFF, 32'h80000001, 32'd1,        DIV_LAT);
        do_op("divu_by0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        do_op("rem_by0",    3'b110, 32'd5,        32'd0,        32'd5,        0);
        do_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        do_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);

        // Result held while the consumer stalls.
        bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd5;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 200 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd25) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_result", bus.result, 32'd25);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", 32'(bus.out_valid), 32'd0);
        check("hold_release_ready", 32'(bus.in_ready),  32'd1);

        // Kill at CALC iteration 10.
        bus.op = 3'b100; bus.a = 32'd1000; bus.b = 32'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("kill_busy_before", 32'(bus.busy), 32'd1);
        bus.kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_out_valid", 32'(bus.out_valid), 32'd0);
        check("kill_in_ready",  32'(bus.in_ready),  32'd1);
        check("kill_busy",      32'(bus.busy),      32'd0);
        check("kill_result",    bus.result,         32'd25);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check("kill_no_result", 32'(seen), 32'd0);

        // Kill together with a request in IDLE: nothing accepted.
        bus.op = 3'b000; bus.a = 32'd2; bus.b = 32'd2;
        bus.kill = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b0;
        bus.in_valid = 1'b0;
        check("idle_kill_ready", 32'(bus.in_ready), 32'd1);
        check("idle_kill_busy",  32'(bus.busy),     32'd0);
        repeat (2) @(negedge clk);
        check("idle_kill_valid", 32'(bus.out_valid), 32'd0);

        do_op("after_kill_divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);

        // Asynchronous reset in the middle of CALC.
        bus.op = 3'b000; bus.a = 32'd9; bus.b = 32'd9;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_result",    bus.result,         32'd0);
        check("arst_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op("post_rst_mul", 3'b000, 32'd3, 32'd3, 32'd9, MUL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit. It replaces the single-cycle combinational mul/div/rem ALU path with a multi-cycle block parametrised in width. The block implements all eight M-extension ops, including signed/unsigned high products and the architected divide-by-zero and overflow results. It sits beside the ALU and exchanges operands and results with the core through valid/ready handshakes; the core stalls while the unit is busy.

Parameters:
XLEN, 32, operand/result width in bits (even, >= 8)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
op  input  3  funct3 of M-extension: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
kill  input  1  synchronous abort of the in-flight op
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  result
busy  output  1  state != IDLE

Behaviour:
- One clock, clk. reset_n is asynchronous and active-low.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, counter=0.
- States and transitions:
  - IDLE: in_ready=1. On the edge with in_valid=1, latch op/a/b. Go to DONE if the op is a div-by-zero or a signed-overflow special case; otherwise go to CALC.
  - CALC: XLEN iterations, one per cycle, then go to FIX. Counter is log2(XLEN)+1 bits wide and counts 0..XLEN-1.
  - FIX: apply sign correction, select low/high product half or quotient/remainder, go to DONE.
  - DONE: out_valid=1 and result is held stable until the edge where out_ready=1, then go to IDLE.
- Latency from the accept edge E: normal ops raise out_valid after edge E+XLEN+1. Special cases raise it after edge E+0, i.e. out_valid is high in the cycle right after acceptance.
- No accept outside IDLE and no same-cycle DONE->accept bypass. Minimum issue interval is 2 cycles for special cases and XLEN+3 cycles for normal ops.
- Multiply: shift-add over unsigned magnitudes into a 2*XLEN product register.
  - Signed operands are negated to magnitude at accept.
  - Result sign = sign(a)^sign(b) for MULH; sign(a) for MULHSU; unsigned for MULHU.
  - MUL returns the low XLEN bits (same for every signedness).
- Divide: restoring radix-2 over magnitudes.
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a).
- Special cases (no iteration):
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - DIV with a=most-negative and b=-1 returns a. REM with the same operands returns 0.
- kill: highest priority after reset. At the next edge go to IDLE, out_valid=0, result keeps its old value. kill in IDLE has no effect.
- reset_n asserted mid-operation: immediate return to the reset values; no result is produced.
- in_valid with kill in the same cycle in IDLE: kill wins, nothing accepted.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle signed (XLEN+1)x(XLEN+1) product in FIX, skipping CALC. Multiply latency becomes out_valid after edge E+1. Divide is unchanged.
- Undefined: iterative multiply as above; no hardware multiplier inferred.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum for op, values equal to funct3;
  - typedef enum for state (IDLE, CALC, FIX, DONE);
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- One sub-module, muldiv_sign_fix: combinational conditional two's-complement negate, parametrised by width. Instantiated for operand magnitudes at accept and for result correction in FIX.

Test Plan:
- MUL a=7 b=6 -> result 42, out_valid after edge E+33 (XLEN=32); in_ready low E+1..E+33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100,7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REM 5,0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; each out_valid one cycle after accept.
- out_ready held low 5 cycles in DONE -> result/out_valid stable; kill at CALC iteration 10 -> IDLE next edge, no out_valid; new op then completes correctly.
- reset_n low mid-CALC -> all outputs at reset values immediately (asynchronous); after release, in_ready=1 and MUL 3*3 -> 9.
